// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the data memory port between master 0 (core LSU)
// and master 1 (debug/boot loader). At most one grant per cycle. Supports
// bus locking with a bounded hold and returns read data to the owning master
// one cycle after its grant.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin tie breaking
// in IDLE; the default build uses fixed priority (master 0 wins ties).
module data_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TRANSFER_WIDTH = 4,
  parameter int unsigned LOCK_MAX       = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      m0_req_i,
  input  logic                      m0_lock_i,
  input  logic                      m0_we_i,
  input  logic [ADDR_WIDTH-1:0]     m0_addr_i,
  input  logic [DATA_WIDTH-1:0]     m0_wdata_i,
  input  logic [TRANSFER_WIDTH-1:0] m0_transfer_i,
  output logic                      m0_gnt_o,
  output logic                      m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]     m0_rdata_o,
  input  logic                      m1_req_i,
  input  logic                      m1_lock_i,
  input  logic                      m1_we_i,
  input  logic [ADDR_WIDTH-1:0]     m1_addr_i,
  input  logic [DATA_WIDTH-1:0]     m1_wdata_i,
  input  logic [TRANSFER_WIDTH-1:0] m1_transfer_i,
  output logic                      m1_gnt_o,
  output logic                      m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]     m1_rdata_o,
  output logic                      we_mem_data_o,
  output logic [ADDR_WIDTH-1:0]     addr_mem_data_o,
  output logic [DATA_WIDTH-1:0]     val_mem_data_write_o,
  input  logic [DATA_WIDTH-1:0]     val_mem_data_read_i,
  output logic [TRANSFER_WIDTH-1:0] write_transfer_mem_data_o
);

  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_lock_cnt;
  logic [CNT_W-1:0] w_lock_cnt_nxt;
  logic             r_last;      // 1: master 1 was granted most recently
  logic             w_last_nxt;
  logic             r_fair;      // forced release pending: favor the other master on the next tie
  logic             w_fair_nxt;
  logic             w_tie1;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             r_pend;
  logic             r_owner;

  // State, lock counter and fairness pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_lock_cnt <= '0;
      r_last     <= 1'b1;
      r_fair     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_last     <= w_last_nxt;
      r_fair     <= w_fair_nxt;
    end
  end

  // Grant decision and next-state logic; grants are suppressed while in reset
  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    w_last_nxt     = r_last;
    w_fair_nxt     = r_fair;
    w_gnt0         = 1'b0;
    w_gnt1         = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    w_tie1         = ~r_last;
`else
    w_tie1         = r_fair & ~r_last;
`endif
    if (rst_n) begin
      case (r_state)
        IDLE: begin
          if (m0_req_i && m1_req_i) begin
            w_gnt0 = ~w_tie1;
            w_gnt1 = w_tie1;
          end else begin
            w_gnt0 = m0_req_i;
            w_gnt1 = m1_req_i;
          end
          if (w_gnt0 || w_gnt1) begin
            w_last_nxt = w_gnt1;
            w_fair_nxt = 1'b0;
            if ((w_gnt0 && m0_lock_i) || (w_gnt1 && m1_lock_i)) begin
              if (LOCK_MAX <= 1) begin
                // The first locked grant already hits the limit
                w_fair_nxt = 1'b1;
              end else begin
                w_state_nxt    = w_gnt1 ? OWN1 : OWN0;
                w_lock_cnt_nxt = CNT_W'(1);
              end
            end
          end
        end
        OWN0: begin
          w_gnt0 = m0_req_i;
          if (m0_req_i) w_last_nxt = 1'b0;
          if (!m0_req_i || !m0_lock_i) begin
            w_state_nxt    = IDLE;
            w_lock_cnt_nxt = '0;
          end else if (r_lock_cnt >= CNT_W'(LOCK_MAX - 1)) begin
            w_state_nxt    = IDLE;
            w_lock_cnt_nxt = '0;
            w_fair_nxt     = 1'b1;
          end else begin
            w_lock_cnt_nxt = r_lock_cnt + CNT_W'(1);
          end
        end
        OWN1: begin
          w_gnt1 = m1_req_i;
          if (m1_req_i) w_last_nxt = 1'b1;
          if (!m1_req_i || !m1_lock_i) begin
            w_state_nxt    = IDLE;
            w_lock_cnt_nxt = '0;
          end else if (r_lock_cnt >= CNT_W'(LOCK_MAX - 1)) begin
            w_state_nxt    = IDLE;
            w_lock_cnt_nxt = '0;
            w_fair_nxt     = 1'b1;
          end else begin
            w_lock_cnt_nxt = r_lock_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt    = IDLE;
          w_lock_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Memory-side mux: granted master's fields, all zero when nothing is granted
  always_comb begin
    we_mem_data_o             = 1'b0;
    addr_mem_data_o           = '0;
    val_mem_data_write_o      = '0;
    write_transfer_mem_data_o = '0;
    if (w_gnt0) begin
      we_mem_data_o             = m0_we_i;
      addr_mem_data_o           = m0_addr_i;
      val_mem_data_write_o      = m0_wdata_i;
      write_transfer_mem_data_o = m0_transfer_i;
    end else if (w_gnt1) begin
      we_mem_data_o             = m1_we_i;
      addr_mem_data_o           = m1_addr_i;
      val_mem_data_write_o      = m1_wdata_i;
      write_transfer_mem_data_o = m1_transfer_i;
    end
  end

  // Capture owner and read-pending flag at every grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend  <= 1'b0;
      r_owner <= 1'b0;
    end else begin
      r_pend <= (w_gnt0 && !m0_we_i) || (w_gnt1 && !m1_we_i);
      if (w_gnt0 || w_gnt1) r_owner <= w_gnt1;
    end
  end

  // Response steering: memory read data goes to the owner only
  always_comb begin
    m0_gnt_o    = w_gnt0;
    m1_gnt_o    = w_gnt1;
    m0_rvalid_o = r_pend & ~r_owner;
    m1_rvalid_o = r_pend & r_owner;
    m0_rdata_o  = m0_rvalid_o ? val_mem_data_read_i : '0;
    m1_rdata_o  = m1_rvalid_o ? val_mem_data_read_i : '0;
  end

endmodule
